pmem_burst_adapter: RTL and testbench
=====================================

Name: pmem_burst_adapter

Overview:
- Responder for the line-wide physical-memory handshake that the L2 cache controller drives: pmem_read/pmem_write held until a one-cycle pmem_resp.
- Serves each 128-bit line request as a burst of 16-bit word beats on a narrow req/ack memory port.
- Sits between the L2 cache datapath/control and the word-wide main memory model.

Parameters:
- LINE_BITS, 128, line width on the pmem side
- WORD_BITS, 16, word width on the narrow side; BEATS = LINE_BITS/WORD_BITS (8)
- ADDR_BITS, 16, byte address width on both sides

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; returns the block to IDLE
- pmem_read  in  1  line read request, held until pmem_resp
- pmem_write  in  1  line write request, held until pmem_resp
- pmem_address  in  ADDR_BITS  byte address of the line; the low log2(LINE_BITS/8) bits are ignored
- pmem_wdata  in  LINE_BITS  write line
- pmem_rdata  out  LINE_BITS  last completed read line
- pmem_resp  out  1  one-cycle completion pulse
- nm_req  out  1  narrow beat request
- nm_we  out  1  narrow beat is a write
- nm_addr  out  ADDR_BITS  narrow byte address
- nm_wdata  out  WORD_BITS  narrow write word
- nm_rdata  in  WORD_BITS  narrow read word, valid with nm_ack
- nm_ack  in  1  beat complete when nm_req && nm_ack

Behaviour:
- Reset: state IDLE, beat counter 0, and all outputs 0, including pmem_rdata. If reset asserts mid-burst, nm_req drops immediately and no pmem_resp is issued.
- States are IDLE, WR_BURST, RD_BURST, RESP, DRAIN.
- IDLE:
  - pmem_write=1 at a rising edge: capture the line base (address with low bits cleared) and wdata, counter=0, go to WR_BURST.
  - Otherwise pmem_read=1: capture the line base, counter=0, go to RD_BURST.
  - If both are high, write wins.
- WR_BURST / RD_BURST:
  - nm_req=1. nm_we=1 in WR_BURST only.
  - nm_addr = base + 2*counter.
  - nm_wdata = captured wdata[WORD_BITS*counter +: WORD_BITS].
  - nm_addr, nm_we and nm_wdata stay stable until the beat completes; nm_ack is ignored while nm_req=0.
  - On each completed beat, counter increments. In RD_BURST, nm_rdata is stored into word slot [counter] of an internal line register.
  - On completion of beat BEATS-1, go to RESP.
  - Ascending word order, no wrap-around within the line.
- RESP:
  - pmem_resp=1 for exactly one cycle.
  - For a read, pmem_rdata takes the assembled line in this cycle and holds it until the next completed read.
  - Next state is IDLE unconditionally. A request present in the cycle after RESP (e.g. the read that follows a write-back) is accepted from IDLE with no bubble beyond that cycle.
- Abort:
  - If the active command input (pmem_write in WR_BURST, pmem_read in RD_BURST) is low in any burst cycle, go to DRAIN.
  - DRAIN keeps nm_req and the current beat signals until nm_ack, then goes to IDLE.
  - No pmem_resp is issued and pmem_rdata is unchanged. A partially written line in memory is acceptable.
- Latency:
  - The request is first high in cycle 0.
  - With nm_ack held at 1, the beats occupy cycles 1..8 and pmem_resp is high in cycle 9.
  - Each ack wait state adds one cycle.
- pmem_address and pmem_wdata are sampled only at acceptance; later changes are ignored.

Decomposition:
- lc3b_types gains:
  - lc3b_line (128-bit) and lc3b_word, if not already present
  - constant PMEM_BEATS = 8
  - constant PMEM_OFFSET_BITS = 4
  - the enum pmem_adapter_state_t
- One sub-module, line_word_reg: a LINE_BITS register with a word-slot write enable and a WORD_BITS-wide write port, used for read-line assembly.
- Control and counter stay in pmem_burst_adapter.

Test Plan:
1. Read, zero wait: pmem_read with address 0x1236, nm_ack tied 1, memory word at byte 0x1230+2i = 0xA000+i → nm_addr 0x1230,0x1232..0x123E; pmem_resp only in cycle 9; pmem_rdata = {0xA007..0xA000}, still held 5 cycles later.
2. Write, ack after 2 wait cycles per beat: pmem_write with address 0x0040, wdata word i = 0x5550+i → 8 beats at 0x0040..0x004E with nm_we=1 and matching words; signals stable across waits; pmem_resp in cycle 25.
3. Write-back then replace: pmem_write at 0x0080, then pmem_read at 0x0100 asserted the cycle after resp → read burst starts in the next cycle at 0x0100; exactly two pmem_resp pulses.
4. Abort: drop pmem_read after the 3rd ack while beat 3 is waiting on ack → nm_req stays high until ack, then IDLE; no pmem_resp; pmem_rdata unchanged from the prior read.
5. Reset mid-burst: assert reset asynchronously during beat 4 of a write → nm_req, pmem_resp and pmem_rdata are 0 immediately; a fresh read after reset starts at beat 0.
6. pmem_read and pmem_write both high at 0x0200 → write burst performed; pmem_rdata not updated.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types and constants for the L2 to main-memory path.
package lc3b_types;

  typedef logic [127:0] lc3b_line;
  typedef logic [15:0]  lc3b_word;

  // Word beats per line and byte-offset bits inside a line.
  localparam int PMEM_BEATS       = 8;
  localparam int PMEM_OFFSET_BITS = 4;

  typedef enum logic [2:0] {
    PMEM_IDLE,
    PMEM_WR_BURST,
    PMEM_RD_BURST,
    PMEM_RESP,
    PMEM_DRAIN
  } pmem_adapter_state_t;

endpackage

// File: rtl/line_word_reg.sv
// Line-wide register written one word slot at a time; assembles read lines.
module line_word_reg #(
  parameter int LINE_BITS = 128,
  parameter int WORD_BITS = 16
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  we,
  input  logic [$clog2(LINE_BITS/WORD_BITS)-1:0] slot,
  input  logic [WORD_BITS-1:0]                  wdata,
  output logic [LINE_BITS-1:0]                  line
);

  // Overwrite only the addressed word slot when enabled.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= '0;
    end else if (we) begin
      line[WORD_BITS*slot +: WORD_BITS] <= wdata;
    end
  end

endmodule

// File: rtl/pmem_burst_adapter.sv
// Turns held line-wide pmem read/write requests into ascending bursts of
// word beats on a req/ack memory port, with abort and drain handling.
module pmem_burst_adapter
  import lc3b_types::*;
#(
  parameter int LINE_BITS = 128,
  parameter int WORD_BITS = 16,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  logic [ADDR_BITS-1:0] pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 pmem_resp,
  output logic                 nm_req,
  output logic                 nm_we,
  output logic [ADDR_BITS-1:0] nm_addr,
  output logic [WORD_BITS-1:0] nm_wdata,
  input  logic [WORD_BITS-1:0] nm_rdata,
  input  logic                 nm_ack
);

  localparam int BEATS       = LINE_BITS / WORD_BITS;
  localparam int CNT_W       = $clog2(BEATS);
  localparam int OFFSET_BITS = $clog2(LINE_BITS / 8);
  localparam int WORD_BYTES  = WORD_BITS / 8;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  pmem_adapter_state_t state;
  logic [CNT_W-1:0]     cnt;
  logic [CNT_W-1:0]     next_cnt;
  logic [ADDR_BITS-1:0] base;
  logic [ADDR_BITS-1:0] req_base;
  logic [LINE_BITS-1:0] wdata_q;
  logic [LINE_BITS-1:0] line_q;
  logic [LINE_BITS-1:0] merged_line;
  logic                 beat_done;
  logic                 cmd_active;
  logic                 slot_we;
  logic                 unused_offset;

  // Byte address of word slot idx within the line starting at b.
  function automatic logic [ADDR_BITS-1:0] beat_addr(input logic [ADDR_BITS-1:0] b,
                                                     input logic [CNT_W-1:0] idx);
    return b + ADDR_BITS'(idx) * ADDR_BITS'(WORD_BYTES);
  endfunction

  // Word slot idx of a line.
  function automatic logic [WORD_BITS-1:0] word_of(input logic [LINE_BITS-1:0] l,
                                                   input logic [CNT_W-1:0] idx);
    return l[WORD_BITS*idx +: WORD_BITS];
  endfunction

  // Byte offset inside the line is intentionally dropped.
  assign unused_offset = ^pmem_address[OFFSET_BITS-1:0];
  assign req_base      = {pmem_address[ADDR_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign beat_done     = nm_req && nm_ack;
  assign next_cnt      = cnt + 1'b1;
  assign slot_we       = beat_done && (state == PMEM_RD_BURST);

  // The command that must stay asserted for the current burst to continue.
  always_comb begin
    cmd_active = 1'b0;
    case (state)
      PMEM_WR_BURST: cmd_active = pmem_write;
      PMEM_RD_BURST: cmd_active = pmem_read;
      default:       cmd_active = 1'b0;
    endcase
  end

  // Assembled line including the word arriving this cycle, so the final
  // beat and the pmem_rdata update land on the same edge.
  always_comb begin
    merged_line = line_q;
    merged_line[WORD_BITS*cnt +: WORD_BITS] = nm_rdata;
  end

  line_word_reg #(
    .LINE_BITS(LINE_BITS),
    .WORD_BITS(WORD_BITS)
  ) u_line (
    .clk  (clk),
    .reset(reset),
    .we   (slot_we),
    .slot (cnt),
    .wdata(nm_rdata),
    .line (line_q)
  );

  // Burst control FSM with registered narrow-port and pmem outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= PMEM_IDLE;
      cnt        <= '0;
      base       <= '0;
      wdata_q    <= '0;
      nm_req     <= 1'b0;
      nm_we      <= 1'b0;
      nm_addr    <= '0;
      nm_wdata   <= '0;
      pmem_resp  <= 1'b0;
      pmem_rdata <= '0;
    end else begin
      pmem_resp <= 1'b0;
      unique case (state)
        PMEM_IDLE: begin
          // Write wins when both requests are present.
          if (pmem_write) begin
            state    <= PMEM_WR_BURST;
            cnt      <= '0;
            base     <= req_base;
            wdata_q  <= pmem_wdata;
            nm_req   <= 1'b1;
            nm_we    <= 1'b1;
            nm_addr  <= req_base;
            nm_wdata <= pmem_wdata[WORD_BITS-1:0];
          end else if (pmem_read) begin
            state    <= PMEM_RD_BURST;
            cnt      <= '0;
            base     <= req_base;
            nm_req   <= 1'b1;
            nm_we    <= 1'b0;
            nm_addr  <= req_base;
            nm_wdata <= '0;
          end
        end
        PMEM_WR_BURST, PMEM_RD_BURST: begin
          if (!cmd_active) begin
            // Withdrawn request: finish only the beat already on the bus.
            if (beat_done) begin
              state  <= PMEM_IDLE;
              nm_req <= 1'b0;
              nm_we  <= 1'b0;
            end else begin
              state <= PMEM_DRAIN;
            end
          end else if (beat_done) begin
            if (cnt == LAST_BEAT) begin
              state     <= PMEM_RESP;
              pmem_resp <= 1'b1;
              nm_req    <= 1'b0;
              nm_we     <= 1'b0;
              if (state == PMEM_RD_BURST) begin
                pmem_rdata <= merged_line;
              end
            end else begin
              cnt     <= next_cnt;
              nm_addr <= beat_addr(base, next_cnt);
              if (state == PMEM_WR_BURST) begin
                nm_wdata <= word_of(wdata_q, next_cnt);
              end
            end
          end
        end
        PMEM_DRAIN: begin
          if (beat_done) begin
            state  <= PMEM_IDLE;
            nm_req <= 1'b0;
            nm_we  <= 1'b0;
          end
        end
        PMEM_RESP: begin
          state <= PMEM_IDLE;
        end
        default: begin
          state  <= PMEM_IDLE;
          nm_req <= 1'b0;
          nm_we  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_burst_adapter.sv
// Directed and randomized bench for pmem_burst_adapter with a word memory
// responder and line-level expectations.
module tb_pmem_burst_adapter;
  import lc3b_types::*;

  logic       clk;
  logic       reset;
  logic       pmem_read;
  logic       pmem_write;
  lc3b_word   pmem_address;
  lc3b_line   pmem_wdata;
  lc3b_line   pmem_rdata;
  logic       pmem_resp;
  logic       nm_req;
  logic       nm_we;
  lc3b_word   nm_addr;
  lc3b_word   nm_wdata;
  lc3b_word   nm_rdata;
  logic       nm_ack;

  pmem_burst_adapter #(
    .LINE_BITS(128),
    .WORD_BITS(16),
    .ADDR_BITS(16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pmem_read   (pmem_read),
    .pmem_write  (pmem_write),
    .pmem_address(pmem_address),
    .pmem_wdata  (pmem_wdata),
    .pmem_rdata  (pmem_rdata),
    .pmem_resp   (pmem_resp),
    .nm_req      (nm_req),
    .nm_we       (nm_we),
    .nm_addr     (nm_addr),
    .nm_wdata    (nm_wdata),
    .nm_rdata    (nm_rdata),
    .nm_ack      (nm_ack)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic     we;
    lc3b_word addr;
    lc3b_word wdata;
  } beat_t;

  lc3b_word mem [0:32767];
  beat_t    beats[$];
  int       wait_cfg;
  int       unstable_cnt;
  int       resp_total;
  int       n_checks;
  int       n_fails;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word memory: commits the beat that completed at the last rising edge,
  // flags beat signals that move while waiting, then drives ack/rdata.
  initial begin
    int  wait_cnt;
    bit  p_req, p_ack, p_we;
    lc3b_word p_addr, p_wdata;
    wait_cnt = 0;
    p_req = 0; p_ack = 0; p_we = 0; p_addr = '0; p_wdata = '0;
    unstable_cnt = 0;
    resp_total = 0;
    nm_ack = 1'b0;
    nm_rdata = '0;
    for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < PMEM_BEATS; i++) mem[15'(16'h1230 >> 1) + 15'(i)] = 16'hA000 + 16'(i);
    forever begin
      @(negedge clk);
      if (pmem_resp) resp_total++;
      if (!reset && p_req && p_ack) begin
        beats.push_back('{p_we, p_addr, p_we ? p_wdata : 16'h0});
        if (p_we) mem[p_addr[15:1]] = p_wdata;
        wait_cnt = 0;
      end else if (!reset && p_req && nm_req) begin
        if ({nm_we, nm_addr, nm_wdata} !== {p_we, p_addr, p_wdata}) unstable_cnt++;
      end
      if (reset) begin
        nm_ack = 1'b0;
        wait_cnt = 0;
      end else if (nm_req) begin
        if (wait_cnt >= wait_cfg) begin
          nm_ack = 1'b1;
          nm_rdata = mem[nm_addr[15:1]];
        end else begin
          nm_ack = 1'b0;
          nm_rdata = 16'($urandom);
          wait_cnt++;
        end
      end else begin
        nm_ack = 1'($urandom_range(0, 1));
        nm_rdata = 16'($urandom);
        wait_cnt = 0;
      end
      p_req = nm_req && !reset;
      p_ack = nm_ack;
      p_we = nm_we;
      p_addr = nm_addr;
      p_wdata = nm_wdata;
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic go_idle();
    @(posedge clk);
    #1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
  endtask

  // One complete transaction; returns in the pmem_resp cycle with the
  // request still held, so a follow-on request can start next cycle.
  task automatic run_txn(input string tag, input logic wr, input logic rd,
                         input lc3b_word addr, input lc3b_line wd, input int waits);
    lc3b_word base;
    lc3b_line exp_line, prev_rdata;
    logic [32:0] obs_b, exp_b;
    int cyc, resp_cyc, first_req, bb, u0;
    base = {addr[15:PMEM_OFFSET_BITS], {PMEM_OFFSET_BITS{1'b0}}};
    for (int i = 0; i < PMEM_BEATS; i++) exp_line[16*i +: 16] = mem[base[15:1] + 15'(i)];
    prev_rdata = pmem_rdata;
    bb = beats.size();
    u0 = unstable_cnt;
    wait_cfg = waits;
    @(posedge clk);
    #1;
    pmem_write = wr;
    pmem_read = rd;
    pmem_address = addr;
    pmem_wdata = wd;
    cyc = 0;
    resp_cyc = -1;
    first_req = -1;
    while (resp_cyc < 0 && cyc < 400) begin
      step();
      if (nm_req && first_req < 0) first_req = cyc;
      if (pmem_resp) begin
        resp_cyc = cyc;
      end else begin
        @(posedge clk);
        #1;
        cyc++;
        pmem_address = 16'($urandom);
        pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    check({tag, " resp_cycle"}, 128'(resp_cyc), 128'(8 * (waits + 1) + 1));
    check({tag, " first_beat_cycle"}, 128'(first_req), 128'(1));
    check({tag, " beat_count"}, 128'(beats.size() - bb), 128'(PMEM_BEATS));
    for (int i = 0; i < PMEM_BEATS; i++) begin
      if (bb + i < beats.size()) begin
        obs_b = beats[bb + i];
        exp_b = {wr, base + 16'(2 * i), wr ? wd[16*i +: 16] : 16'h0};
        check($sformatf("%s beat%0d", tag, i), 128'(obs_b), 128'(exp_b));
      end
    end
    if (!wr) check({tag, " rdata"}, pmem_rdata, exp_line);
    else     check({tag, " rdata_kept"}, pmem_rdata, prev_rdata);
    check({tag, " stable_while_waiting"}, 128'(unstable_cnt - u0), 128'(0));
  endtask

  initial begin
    lc3b_line wd, exp_line, prior;
    lc3b_word addr;
    int r0, bb, cyc, early_drop;
    n_checks = 0;
    n_fails = 0;
    wait_cfg = 0;
    reset = 1'b1;
    pmem_read = 1'b0;
    pmem_write = 1'b0;
    pmem_address = '0;
    pmem_wdata = '0;
    repeat (2) @(posedge clk);
    step();
    check("reset nm_req", 128'(nm_req), 128'(0));
    check("reset nm_we", 128'(nm_we), 128'(0));
    check("reset nm_addr_wdata", 128'({nm_addr, nm_wdata}), 128'(0));
    check("reset pmem_resp", 128'(pmem_resp), 128'(0));
    check("reset pmem_rdata", pmem_rdata, 128'(0));
    reset = 1'b0;

    // Read, zero wait states.
    run_txn("t1_read", 1'b0, 1'b1, 16'h1236, '0, 0);
    for (int i = 0; i < PMEM_BEATS; i++) exp_line[16*i +: 16] = 16'hA000 + 16'(i);
    check("t1 rdata_const", pmem_rdata, exp_line);
    go_idle();
    step();
    check("t1 resp_one_cycle", 128'(pmem_resp), 128'(0));
    repeat (4) step();
    check("t1 rdata_held", pmem_rdata, exp_line);

    // Write, two wait cycles per beat.
    for (int i = 0; i < PMEM_BEATS; i++) wd[16*i +: 16] = 16'h5550 + 16'(i);
    run_txn("t2_write", 1'b1, 1'b0, 16'h0040, wd, 2);
    go_idle();

    // Write-back immediately followed by the replacing read.
    step();
    r0 = resp_total;
    wd = {$urandom, $urandom, $urandom, $urandom};
    run_txn("t3_write", 1'b1, 1'b0, 16'h0080, wd, $urandom_range(0, 1));
    run_txn("t3_read", 1'b0, 1'b1, 16'h0100, '0, 0);
    go_idle();
    repeat (3) step();
    check("t3 resp_pulses", 128'(resp_total - r0), 128'(2));

    // Abort a read while beat 3 waits for ack.
    prior = pmem_rdata;
    r0 = resp_total;
    bb = beats.size();
    wait_cfg = 3;
    @(posedge clk);
    #1;
    pmem_read = 1'b1;
    pmem_address = 16'h0300;
    cyc = 0;
    while (beats.size() - bb < 3 && cyc < 200) begin
      step();
      cyc++;
    end
    check("t4 three_beats_done", 128'(beats.size() - bb), 128'(3));
    check("t4 beat3_pending", 128'(nm_req), 128'(1));
    go_idle();
    early_drop = 0;
    cyc = 0;
    while (beats.size() - bb < 4 && cyc < 50) begin
      step();
      cyc++;
      if (beats.size() - bb < 4 && !nm_req) early_drop++;
    end
    check("t4 req_held_until_ack", 128'(early_drop), 128'(0));
    check("t4 beat_total", 128'(beats.size() - bb), 128'(4));
    if (beats.size() - bb >= 4) check("t4 beat3", 128'(beats[bb + 3]), 128'({1'b0, 16'h0306, 16'h0}));
    check("t4 req_low_after_ack", 128'(nm_req), 128'(0));
    repeat (3) step();
    check("t4 idle_no_new_beats", 128'(beats.size() - bb), 128'(4));
    check("t4 no_resp", 128'(resp_total - r0), 128'(0));
    check("t4 rdata_unchanged", pmem_rdata, prior);

    // Asynchronous reset during beat 4 of a write.
    bb = beats.size();
    wait_cfg = 1;
    @(posedge clk);
    #1;
    pmem_write = 1'b1;
    pmem_address = 16'h0400;
    pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
    cyc = 0;
    while (beats.size() - bb < 4 && cyc < 200) begin
      step();
      cyc++;
    end
    check("t5 at_beat4", 128'(beats.size() - bb), 128'(4));
    #2;
    reset = 1'b1;
    pmem_write = 1'b0;
    #1;
    check("t5 nm_req_async", 128'(nm_req), 128'(0));
    check("t5 resp_async", 128'(pmem_resp), 128'(0));
    check("t5 rdata_async", pmem_rdata, 128'(0));
    step();
    step();
    reset = 1'b0;
    run_txn("t5_read_after_reset", 1'b0, 1'b1, 16'h0500, '0, 0);
    go_idle();

    // Both requests high: write wins, read data untouched.
    wd = {$urandom, $urandom, $urandom, $urandom};
    run_txn("t6_both", 1'b1, 1'b1, 16'h0200, wd, $urandom_range(0, 2));
    go_idle();

    // Random write then read-back of the same line.
    for (int k = 0; k < 3; k++) begin
      addr = {4'h6, 8'($urandom), 4'($urandom)};
      wd = {$urandom, $urandom, $urandom, $urandom};
      run_txn($sformatf("rnd%0d_write", k), 1'b1, 1'b0, addr, wd, $urandom_range(0, 2));
      run_txn($sformatf("rnd%0d_read", k), 1'b0, 1'b1, addr, '0, $urandom_range(0, 2));
      check($sformatf("rnd%0d readback", k), pmem_rdata, wd);
      go_idle();
    end

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
